// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default framing constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int OS_RATE_DEF = 16;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver tick/line inputs and byte result bundle (parity_err with UART_RX_PARITY_EN)
interface uart_rx_if #(parameter int DBIT = uart_pkg::DBIT_DEF);

  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;

  modport master (output s_tick, rx, input dout, rx_done_tick, frame_err, parity_err);
  modport slave  (input s_tick, rx, output dout, rx_done_tick, frame_err, parity_err);
`else
  modport master (output s_tick, rx, input dout, rx_done_tick, frame_err);
  modport slave  (input s_tick, rx, output dout, rx_done_tick, frame_err);
`endif

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous single-bit inputs
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;
  logic s1_d, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver; UART_RX_PARITY_EN adds a parity bit and parity_err
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int OS_RATE = OS_RATE_DEF
`ifdef UART_RX_PARITY_EN
  , parameter int PARITY_ODD = 0
`endif
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int S_MAX = (OS_RATE > SB_TICK) ? OS_RATE : SB_TICK;
  localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [S_W-1:0] MID_CNT  = S_W'(OS_RATE / 2 - 1);
  localparam logic [S_W-1:0] BIT_LAST = S_W'(OS_RATE - 1);
  localparam logic [S_W-1:0] SB_LAST  = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST   = N_W'(DBIT - 1);

  logic rx_s;

  uart_state_e     state_q, state_d;
  logic [S_W-1:0]  s_cnt_q, s_cnt_d;
  logic [N_W-1:0]  n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_reg_q, b_reg_d;
  logic            armed_q, armed_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q, perr_d;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_reg_q <= '0;
      armed_q <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_reg_q <= b_reg_d;
      armed_q <= armed_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_reg_d = b_reg_q;
    armed_d = armed_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      // A start edge only counts once the line has been seen idle-high,
      // so a stuck-low line cannot retrigger frames.
      IDLE: begin
        if (rx_s) armed_d = 1'b1;
        if (armed_q && !rx_s) begin
          s_cnt_d = '0;
          state_d = START;
        end
      end
      START: if (bus.s_tick) begin
        if (s_cnt_q == MID_CNT) begin
          if (!rx_s) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
      end
      DATA: if (bus.s_tick) begin
        if (s_cnt_q == BIT_LAST) begin
          s_cnt_d = '0;
          b_reg_d = {rx_s, b_reg_q[DBIT-1:1]};
          if (n_cnt_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            n_cnt_d = n_cnt_q + 1'b1;
          end
        end else begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bus.s_tick) begin
        if (s_cnt_q == BIT_LAST) begin
          par_d   = rx_s;
          s_cnt_d = '0;
          state_d = STOP;
        end else begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
      end
`endif
      STOP: if (bus.s_tick) begin
        if (s_cnt_q == SB_LAST) begin
          dout_d  = b_reg_q;
          done_d  = 1'b1;
          ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
          perr_d  = ((^b_reg_q) ^ par_q) != PARITY_ODD[0];
`endif
          armed_d = 1'b0;
          state_d = IDLE;
        end else begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr_q;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver that sits directly downstream of the baud-rate tick generator. It consumes the one-clock-wide 16x oversample tick, recovers 8N1 serial frames from the asynchronous `rx` line and presents each byte with a single-cycle done strobe. Received bytes go to the command decoder and FIFO stages of the UART-controlled designs.

## Interface
- `DBIT`, default 8: data bits per frame, LSB first.
- `SB_TICK`, default 16: oversample ticks spent in the stop bit; 16 gives 1 stop bit, 24 gives 1.5, 32 gives 2.
- `OS_RATE`, default 16: ticks per bit. This must match the tick generator.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. It is used only when `UART_RX_PARITY_EN` is defined.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `s_tick`, input, 1: oversample enable pulse from the baud tick generator, one `clk` wide.
- `rx`, input, 1: asynchronous serial line; it idles high.
- `dout`, output, DBIT: last received byte.
- `rx_done_tick`, output, 1: one-`clk` pulse; `dout` is valid in the same cycle.
- `frame_err`, output, 1: stop bit was sampled low for the byte flagged by `rx_done_tick`.
- `parity_err`, output, 1: parity mismatch. This port exists only when `UART_RX_PARITY_EN` is defined.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. All decisions use `rx_s`.
- Registers:
  - `s_cnt`: log2(max(OS_RATE, SB_TICK)) bits, the tick counter.
  - `n_cnt`: log2(DBIT) bits, the bit counter.
  - `b_reg`: DBIT-bit shift register.
  - `armed`: 1 bit.
- State machine:
  - IDLE:
    - `armed` is set whenever `rx_s`=1.
    - When `armed` is set and `rx_s`=0: clear `s_cnt`, then go to START. This is independent of `s_tick`.
  - START, advancing only on `s_tick`:
    - At `s_cnt` = OS_RATE/2-1 (the bit midpoint): if `rx_s`=0, clear `s_cnt` and `n_cnt` and go to DATA.
    - If `rx_s`=1 there, the start is a glitch: go to IDLE with no strobe.
    - Otherwise increment `s_cnt`.
  - DATA, on `s_tick`:
    - At `s_cnt` = OS_RATE-1: set `s_cnt`=0 and shift `b_reg` ← {`rx_s`, `b_reg`[DBIT-1:1]}.
    - If `n_cnt` = DBIT-1, go to PARITY when `UART_RX_PARITY_EN` is defined, otherwise to STOP.
    - Otherwise increment `n_cnt`.
  - PARITY, on `s_tick`: at `s_cnt` = OS_RATE-1, latch the parity sample, set `s_cnt`=0 and go to STOP.
  - STOP, on `s_tick`: at `s_cnt` = SB_TICK-1, do all of the following in the next cycle, then go to IDLE:
    - `dout` ← `b_reg`.
    - `rx_done_tick`=1.
    - `frame_err` ← ~`rx_s`.
    - `parity_err` ← (^`b_reg` ^ parity sample) != PARITY_ODD.
    - clear `armed`.
- `dout`, `frame_err` and `parity_err` hold their values until the next `rx_done_tick`.
- Break or stuck-low line: the frame completes with `frame_err`=1. No new frame starts until `rx_s` has been seen high, because `armed` is cleared.
- When `s_tick` is low, every counter and state holds.

## Timing
- Reset values:
  - state = IDLE.
  - `s_cnt`, `n_cnt`, `b_reg` = 0.
  - `armed` = 0.
  - `dout` = 0.
  - `rx_done_tick`, `frame_err`, `parity_err` = 0.
  - synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame with no strobe; the FSM is in IDLE on the cycle after `rst` is released.
- Synchronizer latency is 2 `clk` cycles.
- Each data bit is sampled OS_RATE ticks after the previous sample, at the bit centre.
- `rx_done_tick` fires 1 `clk` after the tick at which STOP completes: (OS_RATE/2 + DBIT·OS_RATE [+OS_RATE] + SB_TICK) ticks after the start edge is detected.
- `rx_done_tick` is high for exactly one `clk`, regardless of the tick spacing.
- Back-to-back frames are received without gaps: the next falling edge is detected in IDLE as soon as `rx_s` has been high for at least 1 `clk`.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: frame is start + DBIT + parity + stop; the PARITY state and the `parity_err` port exist.
  - Undefined: frame is 8N1-style; the PARITY state, its sample register and the `parity_err` port are removed.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding constants (IDLE, START, DATA, PARITY, STOP; 3 bits);
  - the default `OS_RATE`/`DBIT`/`SB_TICK` values, which are shared with `uart_tx` and the baud tick generator.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with a reset value parameter (1 for `rx`). It is reused for other asynchronous inputs.

## Test plan
- Reset, then `rx` held high for 1000 `clk` with `s_tick` every 163 `clk` → no `rx_done_tick`; `dout`=0x00; state stays IDLE.
- Send 0xA5 as 8N1 at 16 ticks/bit → one `rx_done_tick`, `dout`=0xA5, `frame_err`=0. Strobe arrives within 1 `clk` of tick 8+128+16 after the edge.
- Low glitch of 3 ticks on an idle line → no strobe; FSM returns to IDLE; a following frame of 0x3C is received correctly.
- Frame 0x55 with the stop bit driven low, then line held low for 40 ticks, then high, then frame 0x0F → first strobe with `dout`=0x55 and `frame_err`=1; no spurious frame while the line is low; second strobe with `dout`=0x0F and `frame_err`=0.
- Assert `rst` for 1 `clk` in the middle of data bit 4 of frame 0xFF, then send 0x81 → no strobe for the aborted frame; the next strobe has `dout`=0x81.
- With `UART_RX_PARITY_EN` defined and PARITY_ODD=0:
  - 0xA5 with parity bit 0 → `parity_err`=0.
  - 0xA5 with parity bit 1 → `parity_err`=1 and `dout`=0xA5.
